// File: rtl/wb_icu80186_pkg.sv
// Shared constants for the 80186-style interrupt control unit: register offsets,
// source indices, EOI type codes and control-register bit positions.
package icu80186_pkg;

   localparam int unsigned NUM_SRC = 5;

   localparam logic [3:0] OFF_EOI    = 4'h1;
   localparam logic [3:0] OFF_IMASK  = 4'h4;
   localparam logic [3:0] OFF_PRIMSK = 4'h5;
   localparam logic [3:0] OFF_INSERV = 4'h6;
   localparam logic [3:0] OFF_REQST  = 4'h7;
   localparam logic [3:0] OFF_INTSTS = 4'h8;
   localparam logic [3:0] OFF_TCUCON = 4'h9;
   localparam logic [3:0] OFF_I0CON  = 4'hC;
   localparam logic [3:0] OFF_I1CON  = 4'hD;
   localparam logic [3:0] OFF_I2CON  = 4'hE;
   localparam logic [3:0] OFF_I3CON  = 4'hF;

   localparam int unsigned SRC_TMR = 0;
   localparam int unsigned SRC_I0  = 1;
   localparam int unsigned SRC_I1  = 2;
   localparam int unsigned SRC_I2  = 3;
   localparam int unsigned SRC_I3  = 4;

   localparam logic [4:0] EOI_TMR = 5'd8;
   localparam logic [4:0] EOI_I0  = 5'd12;
   localparam logic [4:0] EOI_I1  = 5'd13;
   localparam logic [4:0] EOI_I2  = 5'd14;
   localparam logic [4:0] EOI_I3  = 5'd15;

   localparam int unsigned NSPEC_BIT = 15;
   localparam int unsigned LTM_BIT   = 4;
   localparam int unsigned MSK_BIT   = 3;

   typedef logic [2:0] pr_t;

endpackage

// File: rtl/wb_icu80186_prio_resolver.sv
// Picks the flagged source with the lowest priority level; ties go to the lowest index
// (TMR, I0, I1, I2, I3).
module icu_prio_resolver
   import icu80186_pkg::*;
(
   input  logic [NUM_SRC-1:0] elig_i,
   input  pr_t  [NUM_SRC-1:0] pr_i,
   output logic               valid_o,
   output logic [2:0]         idx_o
);

   logic       found;
   logic [2:0] idx;
   pr_t        best;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      best  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         // Strict compare keeps the earlier (higher fixed priority) source on a tie.
         if (elig_i[i] && (!found || (pr_i[i] < best))) begin
            found = 1'b1;
            idx   = 3'(i);
            best  = pr_i[i];
         end
      end
   end

   assign valid_o = found;
   assign idx_o   = idx;

endmodule

// File: rtl/wb_icu80186.sv
// 80186-compatible interrupt control unit (master mode, reduced) behind a Wishbone slave
// port; drives intr to the CPU and supplies the interrupt type during inta.
module wb_icu80186
   import icu80186_pkg::*;
#(
   parameter logic [7:0] TMR_VEC  = 8'h08,
   parameter logic [7:0] INT0_VEC = 8'h0C,
   parameter logic [2:0] DEF_PRI  = 3'h7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  wb_adr_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic [1:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   input  logic        tmr_i,
   input  logic [3:0]  irq_i,
   input  logic        inta_i,
   output logic        intr_o,
   output logic [7:0]  vec_o
);

   logic        ack_q, intr_q, inta_q;
   logic [15:0] dat_q, rdata;
   logic [7:0]  vec_q, win_vec;
   logic [4:0]  reqst_q, reqst_d, inserv_q, inserv_d, msk_q, msk_d, hist_q;
   logic [3:0]  ltm_q, ltm_d;
   logic [2:0]  primsk_q, primsk_d;
   pr_t  [4:0]  pr_q, pr_d;

   logic        access, wr_lo, inta_rise;
   logic [4:0]  src_in, edge_mode, elig, ack_set, eoi_clr;
   logic        isr_valid, win_valid;
   logic [2:0]  isr_idx, win_idx, con_src;
   logic [3:0]  isr_lvl;
   logic        unused;

   assign access    = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wr_lo     = access & wb_we_i & wb_sel_i[0];
   assign inta_rise = inta_i & ~inta_q;
   assign src_in    = {irq_i, tmr_i};
   assign edge_mode = {~ltm_q, 1'b1};
   assign con_src   = {1'b0, wb_adr_i[1:0]} + 3'd1;
   assign unused    = ^{wb_sel_i[1], wb_dat_i[14:5]};

   icu_prio_resolver u_isr_res (
      .elig_i  (inserv_q),
      .pr_i    (pr_q),
      .valid_o (isr_valid),
      .idx_o   (isr_idx)
   );

   // Level of the highest-priority source in service; 8 means nothing blocks.
   assign isr_lvl = isr_valid ? {1'b0, pr_q[isr_idx]} : 4'd8;

   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         elig[i] = reqst_q[i] & ~msk_q[i] & (pr_q[i] <= primsk_q) & ({1'b0, pr_q[i]} < isr_lvl);
      end
   end

   icu_prio_resolver u_req_res (
      .elig_i  (elig),
      .pr_i    (pr_q),
      .valid_o (win_valid),
      .idx_o   (win_idx)
   );

   assign win_vec = (win_idx == 3'(SRC_TMR)) ? TMR_VEC : (INT0_VEC + {5'd0, win_idx} - 8'd1);

   always_comb begin
      rdata = '0;
      unique case (wb_adr_i)
         OFF_IMASK:  rdata = {11'd0, msk_q};
         OFF_PRIMSK: rdata = {13'd0, primsk_q};
         OFF_INSERV: rdata = {11'd0, inserv_q};
         OFF_REQST:  rdata = {11'd0, reqst_q};
         OFF_TCUCON: rdata = {12'd0, msk_q[SRC_TMR], pr_q[SRC_TMR]};
         OFF_I0CON, OFF_I1CON, OFF_I2CON, OFF_I3CON:
            rdata = {11'd0, ltm_q[wb_adr_i[1:0]], msk_q[con_src], pr_q[con_src]};
         default:    rdata = '0;
      endcase
   end

   always_comb begin
      ack_set  = '0;
      eoi_clr  = '0;
      reqst_d  = reqst_q;
      msk_d    = msk_q;
      ltm_d    = ltm_q;
      pr_d     = pr_q;
      primsk_d = primsk_q;

      if (inta_rise && win_valid) ack_set[win_idx] = 1'b1;

      if (wr_lo && (wb_adr_i == OFF_EOI)) begin
         if (wb_dat_i[NSPEC_BIT]) begin
            if (isr_valid) eoi_clr[isr_idx] = 1'b1;
         end else begin
            case (wb_dat_i[4:0])
               EOI_TMR: eoi_clr[SRC_TMR] = 1'b1;
               EOI_I0:  eoi_clr[SRC_I0]  = 1'b1;
               EOI_I1:  eoi_clr[SRC_I1]  = 1'b1;
               EOI_I2:  eoi_clr[SRC_I2]  = 1'b1;
               EOI_I3:  eoi_clr[SRC_I3]  = 1'b1;
               default: ;
            endcase
         end
      end

      // A fresh edge outranks the acknowledge clear in the same cycle.
      for (int i = 0; i < NUM_SRC; i++) begin
         if (edge_mode[i]) reqst_d[i] = (src_in[i] & ~hist_q[i]) | (reqst_q[i] & ~ack_set[i]);
         else              reqst_d[i] = src_in[i];
      end

      inserv_d = inserv_q & ~eoi_clr;

      if (wr_lo) begin
         unique case (wb_adr_i)
            OFF_IMASK:  msk_d    = wb_dat_i[4:0];
            OFF_PRIMSK: primsk_d = wb_dat_i[2:0];
            OFF_INSERV: inserv_d = wb_dat_i[4:0];
            OFF_TCUCON: begin
               msk_d[SRC_TMR] = wb_dat_i[MSK_BIT];
               pr_d[SRC_TMR]  = wb_dat_i[2:0];
            end
            OFF_I0CON, OFF_I1CON, OFF_I2CON, OFF_I3CON: begin
               ltm_d[wb_adr_i[1:0]] = wb_dat_i[LTM_BIT];
               msk_d[con_src]       = wb_dat_i[MSK_BIT];
               pr_d[con_src]        = wb_dat_i[2:0];
            end
            default: ;
         endcase
      end

      inserv_d = inserv_d | ack_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         reqst_q  <= '0;
         inserv_q <= '0;
         msk_q    <= 5'h1F;
         ltm_q    <= '0;
         pr_q     <= {NUM_SRC{DEF_PRI}};
         primsk_q <= 3'd7;
         hist_q   <= '0;
         intr_q   <= 1'b0;
         inta_q   <= 1'b0;
         vec_q    <= '0;
      end else begin
         ack_q    <= access;
         dat_q    <= access ? rdata : 16'd0;
         reqst_q  <= reqst_d;
         inserv_q <= inserv_d;
         msk_q    <= msk_d;
         ltm_q    <= ltm_d;
         pr_q     <= pr_d;
         primsk_q <= primsk_d;
         hist_q   <= src_in;
         intr_q   <= inta_rise ? 1'b0 : win_valid;
         inta_q   <= inta_i;
         if (!inta_i && win_valid) vec_q <= win_vec;
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign intr_o   = intr_q;
   assign vec_o    = vec_q;

endmodule

// File: tb/tb_wb_icu80186.sv
// Self-checking bench for wb_icu80186: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the interrupt controller.
module tb_wb_icu80186;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  wb_adr = '0;
   logic [15:0] wb_wdat = '0;
   logic [15:0] wb_rdat;
   logic [1:0]  wb_sel = '0;
   logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0, wb_ack;
   logic        tmr = 1'b0;
   logic [3:0]  irq = '0;
   logic        inta = 1'b0;
   logic        intr;
   logic [7:0]  vec;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   wb_icu80186 dut (
      .clk      (clk),
      .rst      (rst),
      .wb_adr_i (wb_adr),
      .wb_dat_i (wb_wdat),
      .wb_dat_o (wb_rdat),
      .wb_sel_i (wb_sel),
      .wb_we_i  (wb_we),
      .wb_cyc_i (wb_cyc),
      .wb_stb_i (wb_stb),
      .wb_ack_o (wb_ack),
      .tmr_i    (tmr),
      .irq_i    (irq),
      .inta_i   (inta),
      .intr_o   (intr),
      .vec_o    (vec)
   );

   // Behavioural model: index 0 = TMR, 1..4 = I0..I3.
   int m_req[5], m_isr[5], m_msk[5], m_pr[5], m_ltm[5], m_hist[5];
   int m_primsk, m_intr, m_vec, m_ack, m_dat, m_inta_prev;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int vec_of(input int s);
      return (s == 0) ? 'h08 : ('h0C + s - 1);
   endfunction

   function automatic int pack5(input int a[5]);
      int r = 0;
      for (int i = 0; i < 5; i++) r += (a[i] != 0) ? (1 << i) : 0;
      return r;
   endfunction

   function automatic int rd_model(input int adr);
      case (adr)
         4:              return pack5(m_msk);
         5:              return m_primsk;
         6:              return pack5(m_isr);
         7:              return pack5(m_req);
         9:              return (m_msk[0] << 3) | m_pr[0];
         12, 13, 14, 15: return (m_ltm[adr-11] << 4) | (m_msk[adr-11] << 3) | m_pr[adr-11];
         default:        return 0;
      endcase
   endfunction

   task automatic model_step();
      int lvl, itop, win, adr, d, s, k;
      int n_req[5], n_isr[5], n_msk[5], n_pr[5], n_ltm[5];
      bit rise, acc, wr;
      if (rst) begin
         for (int i = 0; i < 5; i++) begin
            m_req[i] = 0; m_isr[i] = 0; m_msk[i] = 1; m_pr[i] = 7; m_ltm[i] = 0; m_hist[i] = 0;
         end
         m_primsk = 7; m_intr = 0; m_vec = 0; m_ack = 0; m_dat = 0; m_inta_prev = 0;
         return;
      end
      lvl = 8; itop = -1;
      for (int i = 0; i < 5; i++)
         if (m_isr[i] != 0 && m_pr[i] < lvl) begin lvl = m_pr[i]; itop = i; end
      win = -1;
      for (int i = 0; i < 5; i++)
         if (m_req[i] != 0 && m_msk[i] == 0 && m_pr[i] <= m_primsk && m_pr[i] < lvl &&
             (win < 0 || m_pr[i] < m_pr[win])) win = i;
      rise = inta && (m_inta_prev == 0);
      acc  = wb_cyc && wb_stb && (m_ack == 0);
      wr   = acc && wb_we && wb_sel[0];
      adr  = int'(wb_adr);
      d    = int'(wb_wdat);
      n_req = m_req; n_isr = m_isr; n_msk = m_msk; n_pr = m_pr; n_ltm = m_ltm;
      for (int i = 0; i < 5; i++) begin
         s = (i == 0) ? int'(tmr) : int'(irq[i-1]);
         if (m_ltm[i] == 0) n_req[i] = ((s != 0 && m_hist[i] == 0) ||
                                        (m_req[i] != 0 && !(rise && win == i))) ? 1 : 0;
         else n_req[i] = s;
      end
      if (wr && adr == 1) begin
         if (((d >> 15) & 1) != 0) begin
            if (itop >= 0) n_isr[itop] = 0;
         end else begin
            k = d & 'h1F;
            if (k == 8) n_isr[0] = 0;
            else if (k >= 12 && k <= 15) n_isr[k-11] = 0;
         end
      end
      m_dat = acc ? rd_model(adr) : 0;
      if (wr) begin
         case (adr)
            4: for (int i = 0; i < 5; i++) n_msk[i] = (d >> i) & 1;
            5: m_primsk = d & 7;
            6: for (int i = 0; i < 5; i++) n_isr[i] = (d >> i) & 1;
            9: begin n_msk[0] = (d >> 3) & 1; n_pr[0] = d & 7; end
            12, 13, 14, 15: begin
               n_ltm[adr-11] = (d >> 4) & 1; n_msk[adr-11] = (d >> 3) & 1; n_pr[adr-11] = d & 7;
            end
            default: ;
         endcase
      end
      if (rise && win >= 0) n_isr[win] = 1;
      m_ack  = acc ? 1 : 0;
      m_intr = rise ? 0 : ((win >= 0) ? 1 : 0);
      if (!inta && win >= 0) m_vec = vec_of(win);
      m_inta_prev = inta;
      m_hist[0] = tmr;
      for (int i = 1; i < 5; i++) m_hist[i] = irq[i-1];
      m_req = n_req; m_isr = n_isr; m_msk = n_msk; m_pr = n_pr; m_ltm = n_ltm;
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (chk_en) begin
         check("intr_o", int'(intr), m_intr);
         check("vec_o", int'(vec), m_vec);
         check("wb_ack_o", int'(wb_ack), m_ack);
         check("wb_dat_o", int'(wb_rdat), m_dat);
      end
   end

   task automatic wb_xfer(input logic [3:0] adr, input logic we, input logic [15:0] d,
                          input logic [1:0] sel, output logic [15:0] rd);
      int n;
      @(negedge clk);
      wb_adr = adr; wb_we = we; wb_wdat = d; wb_sel = sel; wb_cyc = 1'b1; wb_stb = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!wb_ack && n < 4);
      check("wb_ack_latency", n, 1);
      rd = wb_rdat;
      @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wr(input logic [3:0] adr, input logic [15:0] d);
      logic [15:0] rd;
      wb_xfer(adr, 1'b1, d, 2'b11, rd);
   endtask

   task automatic rd_chk(input string name, input logic [3:0] adr, input int exp);
      logic [15:0] rd;
      wb_xfer(adr, 1'b0, 16'h0, 2'b11, rd);
      check(name, int'(rd), exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ack_cycle();
      @(negedge clk); inta = 1'b1;
      @(negedge clk); inta = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      logic [3:0]  offs[10] = '{4'h1, 4'h4, 4'h5, 4'h6, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF, 4'h2};
      logic [3:0]  a;
      logic [15:0] d;

      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_intr", int'(intr), 0);
      check("reset_vec", int'(vec), 0);
      rd_chk("reset_imask", 4'h4, 'h001F);
      rd_chk("reset_primsk", 4'h5, 'h0007);
      rd_chk("reset_i0con", 4'hC, 'h000F);

      // I0 edge request at PR2
      wr(4'hC, 16'h0002);
      wr(4'h5, 16'h0007);
      @(negedge clk); irq[0] = 1'b1;
      @(negedge clk); irq[0] = 1'b0;
      cycles(2);
      check("i0_intr", int'(intr), 1);
      @(negedge clk); inta = 1'b1;
      @(negedge clk);
      check("i0_vec", int'(vec), 'h0C);
      check("i0_intr_drop", int'(intr), 0);
      inta = 1'b0;
      rd_chk("i0_inserv", 4'h6, 'h0002);
      rd_chk("i0_reqst", 4'h7, 'h0000);

      // I1 at PR3 blocked by I0 in service until specific EOI
      wr(4'hD, 16'h0003);
      @(negedge clk); irq[1] = 1'b1;
      @(negedge clk); irq[1] = 1'b0;
      cycles(3);
      check("i1_blocked", int'(intr), 0);
      wr(4'h1, 16'h000C);
      cycles(2);
      check("i1_intr", int'(intr), 1);
      check("i1_vec", int'(vec), 'h0D);
      ack_cycle();
      wr(4'h1, 16'h000D);

      // TMR and I0 tie at PR1: timer first, then I0 after non-specific EOI
      wr(4'h9, 16'h0001);
      wr(4'hC, 16'h0001);
      @(negedge clk); tmr = 1'b1; irq[0] = 1'b1;
      @(negedge clk); tmr = 1'b0; irq[0] = 1'b0;
      cycles(2);
      check("tie_vec_tmr", int'(vec), 'h08);
      ack_cycle();
      cycles(2);
      check("tie_i0_held", int'(intr), 0);
      wr(4'h1, 16'h8000);
      cycles(2);
      check("tie_vec_i0", int'(vec), 'h0C);
      ack_cycle();
      wr(4'h1, 16'h000C);

      // I2 level-triggered
      wr(4'hE, 16'h0012);
      @(negedge clk); irq[2] = 1'b1;
      cycles(3);
      check("lvl_intr", int'(intr), 1);
      check("lvl_vec", int'(vec), 'h0E);
      ack_cycle();
      cycles(2);
      check("lvl_in_service", int'(intr), 0);
      wr(4'h1, 16'h000E);
      cycles(2);
      check("lvl_reassert", int'(intr), 1);
      @(negedge clk); irq[2] = 1'b0;
      rd_chk("lvl_reqst", 4'h7, 'h0000);
      check("lvl_intr_fall", int'(intr), 0);

      // byte lanes and unlisted offsets
      wb_xfer(4'hC, 1'b1, 16'h00FF, 2'b10, rd);
      rd_chk("hi_lane_i0con", 4'hC, 'h0001);
      rd_chk("unmapped_read", 4'h2, 'h0000);
      rd_chk("imask_view", 4'h4, 'h0010);

      // randomized traffic
      for (int it = 0; it < 1500; it++) begin
         @(negedge clk);
         irq = irq ^ (($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0);
         tmr = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) inta = ~inta;
         if (it == 750) begin
            inta = 1'b1;
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            check("rst_mid_inta_intr", int'(intr), 0);
            check("rst_mid_inta_vec", int'(vec), 0);
         end else if ($urandom_range(0, 2) == 0) begin
            a = offs[$urandom_range(0, 9)];
            d = 16'($urandom);
            if (a == 4'h1) d = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'($urandom_range(8, 16));
            else if (a == 4'h4 || a == 4'h6) d = d & 16'hFFF3;
            wb_xfer(a, ($urandom_range(0, 2) != 0), d,
                    ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11, rd);
         end
      end

      @(negedge clk);
      irq = '0; tmr = 1'b0; inta = 1'b0;
      cycles(3);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_icu80186.md
Name: wb_icu80186

Overview:
- 80186-compatible interrupt control unit (master mode, reduced). Wishbone slave in the I/O window 0xFF20–0xFF3E.
- Replaces the always-ack-zero stub on wb_switch slave 2.
- Collects the timer request and four external requests INT0–INT3. INT0 is the tube IRQ, edge-synchronised at top level.
- Resolves priority, drives `intr` to zet, and supplies the interrupt type byte during `inta`. The top-level `dat_i` mux takes the vector from this block instead of the hard-wired 0x0C.

Parameters:
- TMR_VEC, 8'h08, type returned for the timer source
- INT0_VEC, 8'h0C, type for INT0; INT1–INT3 use INT0_VEC+1..+3
- DEF_PRI, 3'h7, reset priority level of every source control register

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wb_adr_i  in  4  word address within block, I/O address bits [4:1] (0xFF20 -> 0)
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_sel_i  in  2  byte lanes
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle
- wb_stb_i  in  1  strobe
- wb_ack_o  out  1  acknowledge
- tmr_i  in  1  timer request, one-clk pulse
- irq_i  in  4  INT3..INT0 requests, already synchronous to clk
- inta_i  in  1  zet interrupt-acknowledge (wb_tgc_o)
- intr_o  out  1  interrupt request to zet (wb_tgc_i)
- vec_o  out  8  interrupt type, valid while inta_i high

Behaviour:
- Reset: every output 0. REQST, INSERV = 0. IMASK = 5'h1F (all masked). PRIMSK = 7. Every source control register = {LTM=0, MSK=1, PR=DEF_PRI}. Edge-detect history = 0.
- Register map (word offset, meaning):
  - 0x1 EOI, write-only, reads 0
  - 0x4 IMASK [4:0] = {I3,I2,I1,I0,TMR}
  - 0x5 PRIMSK [2:0]
  - 0x6 INSERV [4:0]
  - 0x7 REQST [4:0], read-only
  - 0x8 INTSTS, reads 0
  - 0x9 TCUCON [3:0] = {MSK,PR}
  - 0xC–0xF I0CON–I3CON [4:0] = {LTM,MSK,PR}
  - Unlisted offsets read 0; writes to them are ignored.
  - IMASK and the MSK bits are two views of one flop. Writing either updates both.
  - Unused bits read 0.
- Wishbone:
  - `wb_ack_o` <= `cyc & stb & ~wb_ack_o`, giving one-cycle registered ack and 1 wait state.
  - Write takes effect on the same edge that sets ack. The low byte is written only if sel[0], the high byte only if sel[1].
  - `wb_dat_o` is registered on that same edge and is 0 when ack is low.
- Requests:
  - Edge mode (LTM=0): a REQST bit sets on a 0->1 of `irq_i[n]`. The timer always behaves as edge mode on `tmr_i`.
  - Level mode (LTM=1): REQST[n] = `irq_i[n]` each cycle.
  - An edge REQST bit clears on acknowledge of that source.
  - If a new edge arrives on the same cycle as the acknowledge, the set wins.
- Eligibility: source pending AND unmasked AND PR <= PRIMSK AND PR < lowest PR among INSERV bits (strict; no same-level nesting).
- Winner: lowest PR. Ties go by fixed order TMR > I0 > I1 > I2 > I3.
- `intr_o` is registered: it asserts 1 clk after a source becomes eligible and deasserts 1 clk after no source is eligible.
- `vec_o` is registered. It tracks the winner's type while `inta_i` is low and is frozen while `inta_i` is high.
- Acknowledge: on the first cycle `inta_i` is high (rising edge detect):
  - set INSERV[winner];
  - clear edge REQST[winner];
  - `intr_o` <= 0 on the next edge.
  - If no winner exists at the `inta_i` rise (spurious), state is unchanged and `vec_o` keeps its last value.
- EOI write (needs sel[0]):
  - If bit15 (NSPEC) = 1: clear the INSERV bit with the lowest PR, using the tie order above.
  - Else bits[4:0] select the source: 8 -> TMR, 12..15 -> I0..I3. Other values are ignored.
  - EOI on the same cycle as an acknowledge: both apply. If they target the same bit, the acknowledge set wins.
- Reset mid-inta: all state clears. `intr_o` and `vec_o` are 0 on the next cycle.

Decomposition:
- Package icu80186_pkg:
  - register offset constants;
  - source indices SRC_TMR=0..SRC_I3=4;
  - EOI type codes;
  - NSPEC bit position;
  - LTM/MSK bit positions.
- Sub-module icu_prio_resolver: combinational. Takes 5 eligible flags and 5 PR fields. Outputs a valid flag and the winner index. Used twice: for request arbitration and for the non-specific EOI search over INSERV.

Test Plan:
- Reset, then read IMASK, PRIMSK, I0CON -> 0x001F, 0x0007, 0x000F. `intr_o`=0, `vec_o`=0.
- Write I0CON=0x0002 and PRIMSK=7, pulse `irq_i[0]` -> `intr_o`=1 after 1 clk. `inta_i` high -> `vec_o`=0x0C, INSERV=0x02, REQST=0, `intr_o`=0 the next clk.
- I0 in service at PR2, I1CON=0x0003 pulsed -> no `intr_o`. Write EOI=0x000C -> `intr_o`=1 and `vec_o`=0x0D.
- TCUCON=0x0001, I0CON=0x0001, both pulsed on the same clk -> `vec_o`=0x08 first. After NSPEC EOI=0x8000 and a second `inta_i`, `vec_o`=0x0C.
- I2CON=0x0012 (level), hold `irq_i[2]`=1, ack, then EOI=0x000E -> `intr_o` reasserts. Drop `irq_i[2]` -> REQST bit 3 = 0 and `intr_o` falls 1 clk later.
- Byte write sel=2'b10 to I0CON with data 0x00FF -> I0CON unchanged. Read of offset 0x2 -> 0x0000, ack one cycle after stb.
